// File: rtl/des_ip_loader.sv
// des_ip_loader: assembles 8 serial bytes into a 64-bit block and presents the DES initial permutation as L0/R0
// Optional DES_IP_BYPASS_EN adds a bypass port that skips IP for a block when it is high with the block's first byte.
module des_ip_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
`ifdef DES_IP_BYPASS_EN
  input  logic        bypass,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_l,
  output logic [31:0] out_r,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t st, nxt;
  logic [2:0] cnt;
  logic [55:0] sr;
  logic [63:0] blk, ipb, res;
  logic acc, hs, last;
  assign acc = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  assign last = acc && cnt == 3'd7;
  assign blk = {sr, in_byte};
  assign busy = st != IDLE;
  // Block bit n (1-based) lives at blk[64-n]; IP columns run 58,60,62,64 then 57,59,61,63 stepping down by 8.
  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      assign ipb[63-(8*r+c)] = blk[64-((r < 4 ? 58 + 2*r : 49 + 2*r) - 8*c)];
    end
  end
`ifdef DES_IP_BYPASS_EN
  logic byp;
  assign res = byp ? blk : ipb;
  always_ff @(posedge clk)
    if (!rst_n) byp <= 1'b0;
    else if (acc && cnt == 3'd0) byp <= bypass;
`else
  assign res = ipb;
`endif
  always_comb
    nxt = flush ? IDLE :
          (st == IDLE && acc) ? LOAD :
          (st == LOAD && last) ? FULL :
          (st == FULL && hs) ? IDLE : st;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= 3'd0;
      sr <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_l <= '0;
      out_r <= '0;
    end else begin
      st <= nxt;
      in_ready <= nxt != FULL;
      if (flush) begin
        cnt <= 3'd0;
        out_valid <= 1'b0;
      end else begin
        if (acc) begin
          sr <= blk[55:0];
          cnt <= cnt + 3'd1;
        end
        if (last) begin
          {out_l, out_r} <= res;
          out_valid <= 1'b1;
        end else if (hs) out_valid <= 1'b0;
      end
    end
  end
endmodule
